// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for a free-running up/down counter.
// Only the counter's direction (ctrl) is driven. Every decision is taken on
// the value the counter will hold next cycle, so turnarounds land exactly on
// lo/hi with no overshoot. When no run is active, ctrl toggles every cycle and
// the counter stays parked on two adjacent values.
//
//  state | meaning
//  IDLE  | parked, ctrl toggles each cycle; accepts start
//  SEEK  | walking the counter toward lo
//  UP    | rising leg of a round trip, heading for hi
//  DN    | falling leg of a round trip, heading back to lo
module updown_sweep_ctrl #(
    parameter int WIDTH = 32,
    parameter int NW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [NW-1:0]    n_sweeps,
    input  logic [WIDTH-1:0] cnt,
    output logic             ctrl,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NW-1:0]    sweep_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        UP   = 2'd2,
        DN   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t            state, state_nx;
    logic [WIDTH-1:0]  lo_q, hi_q, lo_nx, hi_nx;
    logic [NW-1:0]     n_q, n_nx;
    logic [NW-1:0]     idx_nx, idx_inc;
    logic [WIDTH-1:0]  nxt;
    logic              ctrl_nx, busy_nx, done_nx, err_nx;
    logic              bad_cfg;

    // Value the counter takes at the coming edge; all steering is based on it.
    assign nxt     = ctrl ? (cnt + ONE) : (cnt - ONE);
    assign idx_inc = sweep_idx + {{(NW-1){1'b0}}, 1'b1};
    assign bad_cfg = (hi <= lo) || (n_sweeps == '0);

    // Next-state, next-direction and pulse generation.
    always_comb begin
        state_nx = state;
        lo_nx    = lo_q;
        hi_nx    = hi_q;
        n_nx     = n_q;
        idx_nx   = sweep_idx;
        ctrl_nx  = ctrl;
        done_nx  = 1'b0;
        err_nx   = 1'b0;

        case (state)
            IDLE: begin
                ctrl_nx = ~ctrl;
                if (start && !stop) begin
                    if (bad_cfg) begin
                        err_nx = 1'b1;
                    end else begin
                        lo_nx  = lo;
                        hi_nx  = hi;
                        n_nx   = n_sweeps;
                        idx_nx = '0;
                        // Steer toward the freshly presented lo on this same edge.
                        if (nxt < lo) begin
                            ctrl_nx  = 1'b1;
                            state_nx = SEEK;
                        end else if (nxt > lo) begin
                            ctrl_nx  = 1'b0;
                            state_nx = SEEK;
                        end else begin
                            ctrl_nx  = 1'b1;
                            state_nx = UP;
                        end
                    end
                end
            end
            SEEK: begin
                if (nxt < lo_q) begin
                    ctrl_nx = 1'b1;
                end else if (nxt > lo_q) begin
                    ctrl_nx = 1'b0;
                end else begin
                    ctrl_nx  = 1'b1;
                    state_nx = UP;
                end
            end
            UP: begin
                if (nxt == hi_q) begin
                    ctrl_nx  = 1'b0;
                    state_nx = DN;
                end else begin
                    ctrl_nx = 1'b1;
                end
            end
            DN: begin
                if (nxt == lo_q) begin
                    ctrl_nx = 1'b1;
                    idx_nx  = idx_inc;
                    if (idx_inc == n_q) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = UP;
                    end
                end else begin
                    ctrl_nx = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Abort: park immediately, keep the round-trip count reached so far.
        if ((state != IDLE) && stop) begin
            state_nx = IDLE;
            ctrl_nx  = ~ctrl;
            idx_nx   = sweep_idx;
            done_nx  = 1'b0;
        end

        busy_nx = (state_nx != IDLE);
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            n_q       <= '0;
            ctrl      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sweep_idx <= '0;
        end else begin
            state     <= state_nx;
            lo_q      <= lo_nx;
            hi_q      <= hi_nx;
            n_q       <= n_nx;
            ctrl      <= ctrl_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            err       <= err_nx;
            sweep_idx <= idx_nx;
        end
    end

endmodule
